// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/func values,
// ALU function codes, datapath mux selects and the decoder/FSM interface structs.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH,
        C_J, C_JAL, C_JR, C_SYSCALL, C_ILLEGAL
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV    = 6'h04;
    localparam logic [5:0] F_SRLV    = 6'h06;
    localparam logic [5:0] F_SRAV    = 6'h07;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic SRCA_PC = 1'b0;
    localparam logic SRCA_A  = 1'b1;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   alu_op;
        logic         signed_ext;
        logic         vshamt;
        logic         half;
    } decode_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       signed_ext;
        logic       half_w;
        logic       vshamt;
        logic       halted;
        logic       retire;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational instruction classifier: maps OP/Func to an instruction class plus the
// ALU function, immediate extension mode, variable-shift and halfword flags.
module mc_instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output decode_t    dec
);

    always_comb begin
        dec = '{cls: C_ILLEGAL, alu_op: ALU_ADD, signed_ext: 1'b0, vshamt: 1'b0, half: 1'b0};
        case (op)
            OP_RTYPE: begin
                dec.cls = C_RTYPE;
                case (func)
                    F_ADD, F_ADDU: dec.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: dec.alu_op = ALU_SUB;
                    F_AND:         dec.alu_op = ALU_AND;
                    F_OR:          dec.alu_op = ALU_OR;
                    F_XOR:         dec.alu_op = ALU_XOR;
                    F_NOR:         dec.alu_op = ALU_NOR;
                    F_SLT:         dec.alu_op = ALU_SLT;
                    F_SLTU:        dec.alu_op = ALU_SLTU;
                    F_SLL:         dec.alu_op = ALU_SLL;
                    F_SRL:         dec.alu_op = ALU_SRL;
                    F_SRA:         dec.alu_op = ALU_SRA;
                    F_SLLV:  begin dec.alu_op = ALU_SLL; dec.vshamt = 1'b1; end
                    F_SRLV:  begin dec.alu_op = ALU_SRL; dec.vshamt = 1'b1; end
                    F_SRAV:  begin dec.alu_op = ALU_SRA; dec.vshamt = 1'b1; end
                    F_JR:          dec.cls = C_JR;
                    F_SYSCALL:     dec.cls = C_SYSCALL;
                    default:       dec.cls = C_ILLEGAL;
                endcase
            end
            OP_J:   dec.cls = C_J;
            OP_JAL: dec.cls = C_JAL;
            OP_BEQ, OP_BNE, OP_BLEZ: begin
                dec.cls = C_BRANCH; dec.alu_op = ALU_SUB; dec.signed_ext = 1'b1;
            end
            OP_ADDI: begin dec.cls = C_IMM; dec.alu_op = ALU_ADD; dec.signed_ext = 1'b1; end
            OP_SLTI: begin dec.cls = C_IMM; dec.alu_op = ALU_SLT; dec.signed_ext = 1'b1; end
            OP_ANDI: begin dec.cls = C_IMM; dec.alu_op = ALU_AND; end
            OP_ORI:  begin dec.cls = C_IMM; dec.alu_op = ALU_OR;  end
            OP_LW:   begin dec.cls = C_LOAD;  dec.signed_ext = 1'b1; end
            OP_LH:   begin dec.cls = C_LOAD;  dec.signed_ext = 1'b1; dec.half = 1'b1; end
            OP_SW:   begin dec.cls = C_STORE; dec.signed_ext = 1'b1; end
            OP_SH:   begin dec.cls = C_STORE; dec.signed_ext = 1'b1; dec.half = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_hard_wired_controller.sv
// Multi-cycle hard-wired controller sequencing FETCH/DECODE/EXEC/MEM/WB with a memory
// ready handshake and syscall halt. Optional MC_PERF_COUNTER_EN adds cycle/instruction counters.
module mc_hard_wired_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int STATE_W  = 3
) (
    input  logic [4:0]          LOGISIM_CLOCK_TREE_0,
    input  logic                RST,
    input  logic [5:0]          OP,
    input  logic [5:0]          Func,
    input  logic                Equal,
    input  logic                LEZ,
    input  logic                SysHalt,
    input  logic                Go,
    input  logic                MemReady,
    output logic                MemReq,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic [1:0]          ALU_SrcB,
    output logic                ALU_SrcA,
    output logic                RegWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemToReg,
    output logic                SignedExt,
    output logic                HalfW,
    output logic                Vshamt,
    output logic                Halted,
    output logic                Retire,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
`ifdef MC_PERF_COUNTER_EN
    ,
    output logic [31:0]         CycleCnt,
    output logic [31:0]         InstrCnt
`endif
);

    logic    clk;
    logic    unused_clk_bits;
    state_e  state, next_state;
    decode_t dec;
    ctrl_t   c, ctl;
    logic    branch_taken;

    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign unused_clk_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

    mc_instr_decode u_decode (
        .op   (OP),
        .func (Func),
        .dec  (dec)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        case (OP)
            OP_BEQ:  branch_taken = Equal;
            OP_BNE:  branch_taken = !Equal;
            default: branch_taken = LEZ;
        endcase
    end

    // NOTE: every output and next_state get a default first, so no path can infer a latch.
    always_comb begin
        c          = '0;
        c.alu_op   = ALU_ADD;
        next_state = state;
        case (state)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PCSRC_PC4;
                if (MemReady) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_IMM_SH;
                c.signed_ext = 1'b1;
                next_state   = S_EXEC;
                case (dec.cls)
                    C_J, C_JAL: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = PCSRC_JUMP;
                        c.retire   = 1'b1;
                        next_state = S_FETCH;
                        if (dec.cls == C_JAL) begin
                            c.reg_write  = 1'b1;
                            c.reg_dst    = DST_RA;
                            c.mem_to_reg = WB_PC;
                        end
                    end
                    C_ILLEGAL: begin
                        c.illegal  = 1'b1;
                        c.retire   = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                c.alu_op     = dec.alu_op;
                c.signed_ext = dec.signed_ext;
                c.alu_src_a  = SRCA_A;
                next_state   = S_FETCH;
                case (dec.cls)
                    C_RTYPE: begin
                        c.alu_src_b = SRCB_B;
                        c.vshamt    = dec.vshamt;
                        next_state  = S_WB;
                    end
                    C_IMM: begin
                        c.alu_src_b = SRCB_IMM;
                        next_state  = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        c.alu_src_b = SRCB_IMM;
                        next_state  = S_MEM;
                    end
                    C_BRANCH: begin
                        c.pc_write = branch_taken;
                        c.pc_src   = PCSRC_BRANCH;
                        c.retire   = 1'b1;
                    end
                    C_JR: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = PCSRC_REG;
                        c.retire   = 1'b1;
                    end
                    C_SYSCALL: begin
                        if (SysHalt) next_state = S_HALT;
                        else         c.retire   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.mem_write = (dec.cls == C_STORE);
                c.half_w    = dec.half;
                if (MemReady) begin
                    if (dec.cls == C_STORE) begin
                        c.retire   = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
                next_state  = S_FETCH;
                if (dec.cls == C_LOAD) begin
                    c.mem_to_reg = WB_MDR;
                    c.reg_dst    = DST_RT;
                end else begin
                    c.mem_to_reg = WB_ALU;
                    c.reg_dst    = (dec.cls == C_RTYPE) ? DST_RD : DST_RT;
                end
            end
            S_HALT: begin
                c.halted = 1'b1;
                if (Go) next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Held low during RST so an in-flight request is dropped at once, not at the next edge.
    assign ctl = RST ? '0 : c;

    assign MemReq    = ctl.mem_req;
    assign MemWrite  = ctl.mem_write;
    assign IorD      = ctl.iord;
    assign IRWrite   = ctl.ir_write;
    assign PCWrite   = ctl.pc_write;
    assign PCSrc     = ctl.pc_src;
    assign ALU_OP    = ALU_OP_W'(ctl.alu_op);
    assign ALU_SrcB  = ctl.alu_src_b;
    assign ALU_SrcA  = ctl.alu_src_a;
    assign RegWrite  = ctl.reg_write;
    assign RegDst    = ctl.reg_dst;
    assign MemToReg  = ctl.mem_to_reg;
    assign SignedExt = ctl.signed_ext;
    assign HalfW     = ctl.half_w;
    assign Vshamt    = ctl.vshamt;
    assign Halted    = ctl.halted;
    assign Retire    = ctl.retire;
    assign Illegal   = ctl.illegal;
    assign State     = STATE_W'(state);

`ifdef MC_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            CycleCnt <= '0;
            InstrCnt <= '0;
        end else begin
            if (state != S_HALT) CycleCnt <= CycleCnt + 32'd1;
            if (c.retire)        InstrCnt <= InstrCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_hard_wired_controller.sv
// Scoreboard bench for mc_hard_wired_controller: a per-instruction model pushes expected
// per-cycle outputs, which are popped and compared while the DUT steps through them.
module tb_mc_hard_wired_controller;
    import mc_ctrl_pkg::*;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

    typedef enum logic [3:0] {K_R, K_IMM, K_LD, K_ST, K_BR, K_J, K_JAL, K_JR, K_SYS, K_ILL} kind_e;

    typedef struct packed {
        logic [2:0] st;
        logic mem_req, mem_write, iord, ir_write, pc_write;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [1:0] src_b;
        logic src_a, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic signed_ext, half_w, vshamt, halted, retire, illegal;
    } obs_t;

    typedef struct packed {
        logic rdy;
        logic go;
        obs_t exp;
    } item_t;

    typedef struct packed {
        logic [5:0] op, fn;
        kind_e k;
        logic [3:0] alu;
        logic se, vsh, half, eq, lez, sys;
        logic [1:0] fst, mst, hc;
    } tcase_t;

    logic clk = 1'b0;
    logic [4:0] clk_tree;
    logic RST, Equal, LEZ, SysHalt, Go, MemReady;
    logic [5:0] OP, Func;
    logic MemReq, MemWrite, IorD, IRWrite, PCWrite, ALU_SrcA, RegWrite;
    logic SignedExt, HalfW, Vshamt, Halted, Retire, Illegal;
    logic [1:0] PCSrc, ALU_SrcB, RegDst, MemToReg;
    logic [3:0] ALU_OP;
    logic [2:0] State;
`ifdef MC_PERF_COUNTER_EN
    logic [31:0] CycleCnt, InstrCnt;
`endif
    obs_t act;

    item_t sb[$];
    int total = 0;
    int bad = 0;
    int exp_instr = 0;
    int exp_cycle = 0;

    assign clk_tree = {clk, 4'b0000};
    always #5 clk = ~clk;

    mc_hard_wired_controller #(.ALU_OP_W(4), .STATE_W(3)) dut (
        .LOGISIM_CLOCK_TREE_0(clk_tree), .RST(RST), .OP(OP), .Func(Func),
        .Equal(Equal), .LEZ(LEZ), .SysHalt(SysHalt), .Go(Go), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALU_OP(ALU_OP), .ALU_SrcB(ALU_SrcB),
        .ALU_SrcA(ALU_SrcA), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .SignedExt(SignedExt), .HalfW(HalfW), .Vshamt(Vshamt), .Halted(Halted),
        .Retire(Retire), .Illegal(Illegal), .State(State)
`ifdef MC_PERF_COUNTER_EN
        , .CycleCnt(CycleCnt), .InstrCnt(InstrCnt)
`endif
    );

    assign act = {State, MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALU_OP, ALU_SrcB,
                  ALU_SrcA, RegWrite, RegDst, MemToReg, SignedExt, HalfW, Vshamt, Halted,
                  Retire, Illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t b;
        b = '0;
        b.st = st;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

    function automatic tcase_t mk(input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                                  input logic [3:0] alu, input logic se, input logic vsh,
                                  input logic half, input logic eq, input logic lez,
                                  input logic sys, input int fst, input int mst, input int hc);
        tcase_t t;
        t.op = op; t.fn = fn; t.k = k; t.alu = alu; t.se = se; t.vsh = vsh; t.half = half;
        t.eq = eq; t.lez = lez; t.sys = sys;
        t.fst = 2'(fst); t.mst = 2'(mst); t.hc = 2'(hc);
        return t;
    endfunction

    task automatic push(input obs_t e, input logic rdy, input logic go);
        item_t it;
        it.exp = e; it.rdy = rdy; it.go = go;
        sb.push_back(it);
        if (e.retire) exp_instr++;
        if (e.st != ST_HALT) exp_cycle++;
    endtask

    task automatic model(input tcase_t t, input bit abort_mem);
        obs_t e;
        logic taken;
        taken = (t.op == 6'h04) ? t.eq : (t.op == 6'h05) ? !t.eq : t.lez;
        e = blank(ST_FETCH); e.mem_req = 1'b1; e.src_b = 2'd1;
        for (int i = 0; i < int'(t.fst); i++) push(e, 1'b0, rb());
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(e, 1'b1, rb());

        e = blank(ST_DECODE); e.src_b = 2'd3; e.signed_ext = 1'b1;
        if (t.k == K_J || t.k == K_JAL || t.k == K_ILL) begin
            e.retire = 1'b1;
            if (t.k == K_ILL) e.illegal = 1'b1;
            else begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
            if (t.k == K_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
            push(e, rb(), rb());
            return;
        end
        push(e, rb(), rb());

        e = blank(ST_EXEC); e.src_a = 1'b1; e.alu_op = t.alu; e.signed_ext = t.se;
        case (t.k)
            K_R:        begin e.vshamt = t.vsh; push(e, rb(), rb()); end
            K_IMM:      begin e.src_b = 2'd2; push(e, rb(), rb()); end
            K_LD, K_ST: begin e.src_b = 2'd2; push(e, rb(), rb()); end
            K_BR:       begin e.pc_write = taken; e.pc_src = 2'd1; e.retire = 1'b1; push(e, rb(), rb()); return; end
            K_JR:       begin e.pc_write = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1; push(e, rb(), rb()); return; end
            default: begin
                e.retire = !t.sys;
                push(e, rb(), rb());
                if (t.sys) begin
                    e = blank(ST_HALT); e.halted = 1'b1;
                    for (int i = 0; i < int'(t.hc); i++) push(e, rb(), 1'b0);
                    push(e, rb(), 1'b1);
                end
                return;
            end
        endcase

        if (t.k == K_LD || t.k == K_ST) begin
            e = blank(ST_MEM); e.mem_req = 1'b1; e.iord = 1'b1;
            e.mem_write = (t.k == K_ST); e.half_w = t.half;
            for (int i = 0; i < int'(t.mst); i++) push(e, 1'b0, rb());
            if (abort_mem) return;
            if (t.k == K_ST) e.retire = 1'b1;
            push(e, 1'b1, rb());
            if (t.k == K_ST) return;
        end

        e = blank(ST_WB); e.reg_write = 1'b1; e.retire = 1'b1;
        if (t.k == K_LD) e.mem_to_reg = 2'd1;
        else e.reg_dst = (t.k == K_R) ? 2'd1 : 2'd0;
        push(e, rb(), rb());
    endtask

    task automatic run_case(input string tag, input tcase_t t, input bit abort_mem);
        item_t it;
        int n;
        OP = t.op; Func = t.fn; Equal = t.eq; LEZ = t.lez; SysHalt = t.sys;
        model(t, abort_mem);
        n = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            MemReady = it.rdy;
            Go = it.go;
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, n), 32'(act), 32'(it.exp));
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        RST = 1'b1; OP = '0; Func = '0; Equal = 1'b0; LEZ = 1'b0; SysHalt = 1'b0;
        Go = 1'b1; MemReady = 1'b1;
        #2;
        check("reset outputs", 32'(act), 32'(0));
        @(posedge clk); #1;
        check("reset held over edge", 32'(act), 32'(0));
`ifdef MC_PERF_COUNTER_EN
        check("reset cycle_cnt", CycleCnt, 32'd0);
        check("reset instr_cnt", InstrCnt, 32'd0);
`endif
        MemReady = 1'b0; Go = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        exp_instr = 0; exp_cycle = 1;
        @(posedge clk); #1;

        run_case("add",   mk(6'h00, 6'h20, K_R,   ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("sllv",  mk(6'h00, 6'h04, K_R,   ALU_SLL, 0, 1, 0, 0, 0, 0, 1, 0, 0), 1'b0);
        run_case("sub",   mk(6'h00, 6'h22, K_R,   ALU_SUB, 0, 0, 0, 0, 0, 0, 2, 0, 0), 1'b0);
        run_case("slt",   mk(6'h00, 6'h2A, K_R,   ALU_SLT, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("addi",  mk(6'h08, 6'h11, K_IMM, ALU_ADD, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
        run_case("andi",  mk(6'h0C, 6'h00, K_IMM, ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("ori",   mk(6'h0D, 6'h3F, K_IMM, ALU_OR,  0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("slti",  mk(6'h0A, 6'h00, K_IMM, ALU_SLT, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("lw",    mk(6'h23, 6'h00, K_LD,  ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 3, 0), 1'b0);
        run_case("lh",    mk(6'h21, 6'h00, K_LD,  ALU_ADD, 1, 0, 1, 0, 0, 0, 2, 1, 0), 1'b0);
        run_case("sw",    mk(6'h2B, 6'h00, K_ST,  ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("sh",    mk(6'h29, 6'h00, K_ST,  ALU_ADD, 1, 0, 1, 0, 0, 0, 1, 2, 0), 1'b0);
        run_case("beq t", mk(6'h04, 6'h00, K_BR,  ALU_SUB, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
        run_case("beq n", mk(6'h04, 6'h00, K_BR,  ALU_SUB, 1, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        run_case("bne t", mk(6'h05, 6'h00, K_BR,  ALU_SUB, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("blez t", mk(6'h06, 6'h00, K_BR, ALU_SUB, 1, 0, 0, 1, 1, 0, 0, 0, 0), 1'b0);
        run_case("blez n", mk(6'h06, 6'h00, K_BR, ALU_SUB, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
        run_case("j",     mk(6'h02, 6'h08, K_J,   ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
        run_case("jal",   mk(6'h03, 6'h00, K_JAL, ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
        run_case("jr",    mk(6'h00, 6'h08, K_JR,  ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("sys run",  mk(6'h00, 6'h0C, K_SYS, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_case("sys halt", mk(6'h00, 6'h0C, K_SYS, ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 3), 1'b0);
        run_case("ill op",   mk(6'h3F, 6'h00, K_ILL, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`ifdef MC_PERF_COUNTER_EN
        check("instr_cnt", InstrCnt, 32'(exp_instr));
        check("cycle_cnt", CycleCnt, 32'(exp_cycle));
`endif
        run_case("ill fn",   mk(6'h00, 6'h01, K_ILL, ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);

        run_case("sw abort", mk(6'h2B, 6'h00, K_ST, ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 2, 0), 1'b1);
        MemReady = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("rst mid-mem state", 32'(State), 32'(ST_FETCH));
        check("rst mid-mem memreq", 32'(MemReq), 32'(0));
        check("rst mid-mem outputs", 32'(act), 32'(0));
        MemReady = 1'b1; Go = 1'b1;
        @(posedge clk); #1;
        check("rst priority over ready", 32'(act), 32'(0));
`ifdef MC_PERF_COUNTER_EN
        check("rst clears instr_cnt", InstrCnt, 32'd0);
`endif
        MemReady = 1'b0; Go = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        exp_instr = 0; exp_cycle = 1;
        @(posedge clk); #1;
        run_case("add after rst", mk(6'h00, 6'h25, K_R, ALU_OR, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
`ifdef MC_PERF_COUNTER_EN
        check("final instr_cnt", InstrCnt, 32'(exp_instr));
        check("final cycle_cnt", CycleCnt, 32'(exp_cycle));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_hard_wired_controller.md
Name: mc_hard_wired_controller

Overview:
- Multi-cycle hard-wired controller. An FSM sequences a shared-memory MIPS datapath through FETCH/DECODE/EXEC/MEM/WB.
- Each instruction takes only the states it needs. The block waits on a memory ready handshake and halts on syscall exit.
- Serves as the sequencing alternative to the single-cycle hard-wired decoder. Drives the PC, IR, register file, ALU and memory-port muxes of the multi-cycle datapath.

Parameters:
- ALU_OP_W, 4, width of ALU_OP.
- STATE_W, 3, width of the state encoding and of the State debug port.

Ports:
- LOGISIM_CLOCK_TREE_0  in  5  clock tree; bit [4] is the global clock; all registers update on its rising edge; other bits unused.
- RST  in  1  asynchronous, active-high reset.
- OP  in  6  IR[31:26].
- Func  in  6  IR[5:0]; valid once IR is loaded.
- Equal  in  1  A==B, from the datapath comparator.
- LEZ  in  1  A<=0 (signed).
- SysHalt  in  1  $v0==10.
- Go  in  1  resume from HALT.
- MemReady  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write strobe, valid with MemReq.
- IorD  out  1  address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register A.
- ALU_OP  out  ALU_OP_W  ALU function.
- ALU_SrcB  out  2  0=B, 1=4, 2=extended imm, 3=extended imm<<2.
- ALU_SrcA  out  1  0=PC, 1=A.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  0=rt, 1=rd, 2=$31.
- MemToReg  out  2  0=ALUOut, 1=MDR, 2=PC.
- SignedExt  out  1  sign-extend the immediate.
- HalfW  out  1  halfword access.
- Vshamt  out  1  variable shift amount.
- Halted  out  1  FSM is in HALT.
- Retire  out  1  one-cycle pulse when an instruction completes.
- Illegal  out  1  one-cycle pulse on an unknown opcode/func.
- State  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6/7 go to FETCH on the next edge.
- Reset: async to FETCH. All strobe outputs go to 0, including MemReq, PCWrite, IRWrite, RegWrite and Retire. Mux selects go to 0. Any in-flight memory request is abandoned.
- FETCH:
  - MemReq=1, IorD=0, ALU_SrcA=0, ALU_SrcB=1, PCSrc=0.
  - Hold until MemReady. In the MemReady cycle: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE:
  - ALU computes the branch target (SrcA=0, SrcB=3). The datapath latches A/B.
  - j: PCWrite, PCSrc=2, Retire, go to FETCH.
  - jal: PCWrite, PCSrc=2, RegWrite, RegDst=2, MemToReg=2, Retire, go to FETCH.
  - Unknown opcode/func: Illegal pulse, Retire, go to FETCH (executes as nop).
  - Everything else goes to EXEC.
- EXEC:
  - R-type ALU: ALU_OP from Func, SrcA=1, SrcB=0. Vshamt=1 for sllv/srlv/srav. Go to WB.
  - addi/andi/ori/slti: SrcB=2. SignedExt=1 except andi/ori. Go to WB.
  - lw/sw/lh/sh: SrcB=2, add, SignedExt=1. Go to MEM.
  - beq/bne/blez: PCWrite = Equal / !Equal / LEZ, PCSrc=1, Retire, go to FETCH.
  - jr: PCWrite, PCSrc=3, Retire, go to FETCH.
  - syscall: if SysHalt, go to HALT with no Retire. Otherwise Retire and go to FETCH.
- MEM:
  - MemReq=1, IorD=1. MemWrite=1 for stores. HalfW=1 for lh/sh.
  - Hold until MemReady. Stores: Retire, go to FETCH. Loads: go to WB.
- WB:
  - RegWrite=1. Loads: MemToReg=1, RegDst=0. ALU ops: MemToReg=0, RegDst=1 for R-type, 0 for immediate.
  - Retire, go to FETCH.
- HALT: Halted=1, no strobes. Go=1 goes to FETCH. Go outside HALT is ignored.
- Latency with MemReady on the first cycle: j/jal 2, branch/jr/syscall 3, R/I/sw 4, lw 5. Each stall cycle on MemReady adds one.
- MemReady outside FETCH/MEM is ignored. MemReq stays high and stable until MemReady.
- RST takes priority over every other event, including during a stall or in HALT.

Optional Feature:
- MC_PERF_COUNTER_EN adds outputs CycleCnt[31:0] and InstrCnt[31:0].
  - CycleCnt increments every non-HALT cycle. InstrCnt increments on Retire.
  - Both clear on RST and wrap modulo 2^32.
- Without the macro, the ports and logic are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode/func constants;
  - ALU_OP codes;
  - PCSrc/ALU_SrcB/RegDst/MemToReg select encodings.
- Sub-module mc_instr_decode: combinational. Classifies OP/Func into an instruction class (RTYPE, IMM, LOAD, STORE, BRANCH, J, JAL, JR, SYSCALL, ILLEGAL), plus ALU_OP and SignedExt. The FSM consumes the class.

Test Plan:
- add (OP=0, Func=0x20), MemReady tied 1 -> states 0,1,2,4,0; RegWrite=1 and RegDst=1 in cycle 4; Retire on cycle 4.
- lw with MemReady low 3 cycles in MEM -> MemReq/IorD=1 held 4 cycles; then WB with MemToReg=1; total 8 cycles.
- beq with Equal=1 -> PCWrite and PCSrc=1 in EXEC. beq with Equal=0 -> PCWrite=0 in EXEC. Both return to FETCH after 3 cycles.
- syscall with SysHalt=1 -> HALT, Halted=1 and no Retire. Go=1 for one cycle -> FETCH next cycle.
- RST asserted mid-MEM of sw -> State=0 and MemReq=0 immediately (async), no Retire. After release, FETCH restarts.
- OP=0x3F -> Illegal and Retire pulse in DECODE; FETCH follows. With MC_PERF_COUNTER_EN, InstrCnt increments by 1.
